// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the handshaked sequential ALU.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_MUL = 4'b0010,
        OP_DIV = 4'b0011
    } op_e;

    // Fixed encoding keeps the state register compatible with the legacy block.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [7:0] BAD_VALUE_DEFAULT = 8'hAC;

endpackage

// File: rtl/alu_seq_div.sv
// Iterative restoring divider: one quotient bit per clock, MSB first.
// The first step runs on the start cycle, so done pulses WIDTH cycles after start.
module alu_seq_div #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rem_q, quo_q, dsr_q;
    logic             done_q;

    logic [WIDTH-1:0] rem_in, quo_in, dsr_in, rem_step, quo_step;
    logic [WIDTH:0]   trial, trial_diff;
    logic             q_bit;

    // quo_q shifts dividend bits out of its top while quotient bits enter at the bottom.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rem_in     = start ? '0 : rem_q;
        quo_in     = start ? dividend : quo_q;
        dsr_in     = start ? divisor : dsr_q;
        trial      = {rem_in, quo_in[WIDTH-1]};
        trial_diff = trial - {1'b0, dsr_in};
        q_bit      = 1'b0;
        rem_step   = trial[WIDTH-1:0];
        if (trial >= {1'b0, dsr_in}) begin
            q_bit    = 1'b1;
            rem_step = trial_diff[WIDTH-1:0];
        end
        quo_step = {quo_in[WIDTH-2:0], q_bit};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: datapath registers are reset too, so an aborted divide leaves nothing visible behind.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q   <= rem_step;
                quo_q   <= quo_step;
                dsr_q   <= divisor;
                count_q <= CW'(WIDTH - 1);
            end else if (count_q != '0) begin
                rem_q   <= rem_step;
                quo_q   <= quo_step;
                count_q <= count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked unsigned ALU: add/sub/mul in one cycle, iterative divide, one op in flight.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] BAD_VALUE = WIDTH'(BAD_VALUE_DEFAULT)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             carry,
    output logic             zero,
    output logic             err,
    output logic             busy
);

    state_e state_q, state_nxt;
    logic   rdy_en_q;

    logic [WIDTH-1:0] result_q, remainder_q;
    logic             carry_q, zero_q, err_q;

    logic [WIDTH-1:0]   res_nxt, rem_nxt;
    logic               carry_nxt, zero_nxt, err_nxt, load_out;
    logic               div_start, div_done;
    logic [WIDTH-1:0]   div_quo, div_rem;
    logic [WIDTH:0]     sum_w;
    logic [WIDTH-1:0]   diff_w;
    logic [2*WIDTH-1:0] prod_w;

    alu_seq_div #(.WIDTH(WIDTH)) u_div (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (div_start),
        .dividend  (a),
        .divisor   (b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign sum_w  = {1'b0, a} + {1'b0, b};
    assign diff_w = a - b;
    assign prod_w = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    always_comb begin
        state_nxt = state_q;
        load_out  = 1'b0;
        div_start = 1'b0;
        res_nxt   = '0;
        rem_nxt   = '0;
        carry_nxt = 1'b0;
        err_nxt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    load_out  = 1'b1;
                    state_nxt = DONE;
                    case (op)
                        OP_ADD: begin
                            res_nxt   = sum_w[WIDTH-1:0];
                            carry_nxt = sum_w[WIDTH];
                        end
                        OP_SUB: begin
                            res_nxt   = diff_w;
                            carry_nxt = (a < b);
                        end
                        OP_MUL: begin
                            res_nxt   = prod_w[WIDTH-1:0];
                            carry_nxt = |prod_w[2*WIDTH-1:WIDTH];
                        end
                        OP_DIV: begin
                            if (b == '0) begin
                                res_nxt = '1;
                                rem_nxt = a;
                                err_nxt = 1'b1;
                            end else begin
                                load_out  = 1'b0;
                                div_start = 1'b1;
                                state_nxt = DIV;
                            end
                        end
                        default: begin
                            res_nxt = BAD_VALUE;
                            err_nxt = 1'b1;
                        end
                    endcase
                end
            end
            DIV: begin
                if (div_done) begin
                    load_out  = 1'b1;
                    res_nxt   = div_quo;
                    rem_nxt   = div_rem;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        zero_nxt = (res_nxt == '0);
    end

    // rdy_en_q keeps in_ready low until the first edge after reset releases.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rdy_en_q    <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            rdy_en_q <= 1'b1;
            if (load_out) begin
                result_q    <= res_nxt;
                remainder_q <= rem_nxt;
                carry_q     <= carry_nxt;
                zero_q      <= zero_nxt;
                err_q       <= err_nxt;
            end
        end
    end

    assign in_ready  = rdy_en_q && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
    assign remainder = remainder_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8) using an expected-result queue.
module tb_alu_seq;

    localparam int W      = 8;
    localparam int DIV_LAT = W + 1;

    typedef struct packed {
        logic [W-1:0] result;
        logic [W-1:0] remainder;
        logic         carry;
        logic         zero;
        logic         err;
    } res_t;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, result, remainder;
    logic [3:0]   op;
    logic         carry, zero, err, busy;

    res_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .remainder (remainder),
        .carry     (carry),
        .zero      (zero),
        .err       (err),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] o);
        res_t r;
        logic [15:0] w;
        r = '0;
        case (o)
            4'd0: begin w = 16'(x) + 16'(y); r.result = w[7:0]; r.carry = w[8]; end
            4'd1: begin r.result = x - y; r.carry = (x < y); end
            4'd2: begin w = 16'(x) * 16'(y); r.result = w[7:0]; r.carry = (w > 16'd255); end
            4'd3: begin
                if (y == 0) begin r.result = 8'hFF; r.remainder = x; r.err = 1'b1; end
                else begin r.result = x / y; r.remainder = x % y; end
            end
            default: begin r.result = 8'hAC; r.err = 1'b1; end
        endcase
        r.zero = (r.result == 0);
        return r;
    endfunction

    function automatic res_t observed();
        return '{result: result, remainder: remainder, carry: carry, zero: zero, err: err};
    endfunction

    // Caller is at a negedge with the DUT idle; returns at the negedge where out_valid is seen.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [3:0] top,
                        input bit poke, output res_t obs, output int lat,
                        output bit busy_all, output bit rdy_seen);
        a = ta; b = tb_; op = top; in_valid = 1'b1;
        exp_q.push_back(model(ta, tb_, top));
        @(posedge clock);
        lat = 99; busy_all = 1'b1; rdy_seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (out_valid) begin lat = i; break; end
            busy_all = busy_all & busy;
            rdy_seen = rdy_seen | in_ready;
            in_valid = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            if (poke) begin a = 8'($urandom); b = 8'($urandom); op = 4'($urandom_range(0, 3)); end
        end
        in_valid = 1'b0;
        obs = observed();
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({out_valid, result, remainder, carry, zero, err, busy, in_ready} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b r=%h rm=%h c=%b z=%b e=%b busy=%b rdy=%b want all 0",
                     out_valid, result, remainder, carry, zero, err, busy, in_ready);
        end
        reset_n = 1'b1;
        @(negedge clock);
        n_cmp++;
        if ({in_ready, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_release: got in_ready=%b busy=%b want 1/0", in_ready, busy);
        end
    endtask

    task automatic test_add_sub();
        res_t obs, e; int lat; bit ba, rs;
        logic [W-1:0] va[4] = '{200, 5, 0, 7};
        logic [W-1:0] vb[4] = '{100, 7, 0, 5};
        logic [3:0]   vo[4] = '{0, 1, 0, 1};
        for (int i = 0; i < 4; i++) begin
            send(va[i], vb[i], vo[i], 1'b0, obs, lat, ba, rs);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e || lat != 1) begin
                n_bad++;
                $display("FAIL add_sub[%0d]: got %h lat %0d want %h lat 1", i, obs, lat, e);
            end
            consume();
        end
    endtask

    task automatic test_mul();
        res_t obs, e; int lat; bit ba, rs;
        logic [W-1:0] va[3] = '{16, 15, 255};
        logic [W-1:0] vb[3] = '{16, 17, 1};
        for (int i = 0; i < 3; i++) begin
            send(va[i], vb[i], 4'd2, 1'b0, obs, lat, ba, rs);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e || lat != 1) begin
                n_bad++;
                $display("FAIL mul[%0d]: got %h lat %0d want %h lat 1", i, obs, lat, e);
            end
            consume();
        end
    endtask

    task automatic test_div();
        res_t obs, e; int lat; bit ba, rs;
        send(8'd200, 8'd7, 4'd3, 1'b1, obs, lat, ba, rs);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
            n_bad++;
            $display("FAIL div_200_7: got %h want %h", obs, e);
        end
        n_cmp++;
        if (lat != DIV_LAT) begin
            n_bad++;
            $display("FAIL div_latency: got %0d want %0d", lat, DIV_LAT);
        end
        n_cmp++;
        if (ba !== 1'b1 || rs !== 1'b0) begin
            n_bad++;
            $display("FAIL div_busy_ready: got busy_all=%b ready_seen=%b want 1/0", ba, rs);
        end
        consume();
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL div_no_stray[%0d]: got out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_div_err();
        res_t obs, e; int lat; bit ba, rs;
        send(8'd9, 8'd0, 4'd3, 1'b0, obs, lat, ba, rs);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e || lat != 1) begin
            n_bad++;
            $display("FAIL div_by_zero: got %h lat %0d want %h lat 1", obs, lat, e);
        end
        consume();
        send(8'd3, 8'd4, 4'b1010, 1'b0, obs, lat, ba, rs);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e || lat != 1) begin
            n_bad++;
            $display("FAIL bad_opcode: got %h lat %0d want %h lat 1", obs, lat, e);
        end
        consume();
    endtask

    task automatic test_backpressure();
        res_t obs, e; int lat; bit ba, rs;
        send(8'd50, 8'd60, 4'd0, 1'b0, obs, lat, ba, rs);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e || lat != 1) begin
            n_bad++;
            $display("FAIL bp_result: got %h lat %0d want %h lat 1", obs, lat, e);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 8'd1; b = 8'd1;
            @(negedge clock);
            n_cmp++;
            if (observed() !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got %h v=%b rdy=%b want %h v=1 rdy=0",
                         i, observed(), out_valid, in_ready, e);
            end
        end
        in_valid = 1'b0;
        consume();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_div();
        res_t obs, e; int lat; bit ba, rs;
        a = 8'd100; b = 8'd3; op = 4'd3; in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, result, remainder, carry, zero, err, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_div: got v=%b r=%h rm=%h c=%b z=%b e=%b busy=%b want all 0",
                     out_valid, result, remainder, carry, zero, err, busy);
        end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_div_release: got in_ready=%b busy=%b want 1/0", in_ready, busy);
        end
        send(8'd100, 8'd10, 4'd3, 1'b0, obs, lat, ba, rs);
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e || lat != DIV_LAT) begin
            n_bad++;
            $display("FAIL div_after_reset: got %h lat %0d want %h lat %0d", obs, lat, e, DIV_LAT);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        res_t obs, e; int lat, want_lat; bit ba, rs;
        logic [W-1:0] ra, rb; logic [3:0] ro;
        for (int i = 0; i < 24; i++) begin
            ro = 4'($urandom_range(0, 5));
            ra = 8'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            want_lat = (ro == 4'd3 && rb != 0) ? DIV_LAT : 1;
            send(ra, rb, ro, 1'b0, obs, lat, ba, rs);
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e || lat != want_lat) begin
                n_bad++;
                $display("FAIL b2b[%0d] op=%0d a=%0d b=%0d: got %h lat %0d want %h lat %0d",
                         i, ro, ra, rb, obs, lat, e, want_lat);
            end
            consume();
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_div_err();
        test_backpressure();
        test_reset_mid_div();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
